// File: rtl/bus_pkg.sv
// bus_pkg: shared select-code map, code width and FSM state encoding
// for the bus transfer decoder and its one-hot decode helper.
package bus_pkg;

  localparam int BUS_CODE_W  = 5;
  localparam int BUS_NUM_SRC = 24;

  localparam logic [4:0] BUS_R0     = 5'd0;
  localparam logic [4:0] BUS_R1     = 5'd1;
  localparam logic [4:0] BUS_R2     = 5'd2;
  localparam logic [4:0] BUS_R3     = 5'd3;
  localparam logic [4:0] BUS_R4     = 5'd4;
  localparam logic [4:0] BUS_R5     = 5'd5;
  localparam logic [4:0] BUS_R6     = 5'd6;
  localparam logic [4:0] BUS_R7     = 5'd7;
  localparam logic [4:0] BUS_R8     = 5'd8;
  localparam logic [4:0] BUS_R9     = 5'd9;
  localparam logic [4:0] BUS_R10    = 5'd10;
  localparam logic [4:0] BUS_R11    = 5'd11;
  localparam logic [4:0] BUS_R12    = 5'd12;
  localparam logic [4:0] BUS_R13    = 5'd13;
  localparam logic [4:0] BUS_R14    = 5'd14;
  localparam logic [4:0] BUS_R15    = 5'd15;
  localparam logic [4:0] BUS_HI     = 5'd16;
  localparam logic [4:0] BUS_LO     = 5'd17;
  localparam logic [4:0] BUS_ZHI    = 5'd18;
  localparam logic [4:0] BUS_ZLO    = 5'd19;
  localparam logic [4:0] BUS_PC     = 5'd20;
  localparam logic [4:0] BUS_MDR    = 5'd21;
  localparam logic [4:0] BUS_INPORT = 5'd22;
  localparam logic [4:0] BUS_C      = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_code_onehot.sv
// bus_code_onehot: turns a 5-bit select code into a 24-bit one-hot
// enable vector; codes at or above NUM_CODES give all-zero plus invalid.
module bus_code_onehot
  import bus_pkg::*;
#(
  parameter int NUM_CODES = BUS_NUM_SRC
) (
  input  logic [BUS_CODE_W-1:0]  code,
  output logic [BUS_NUM_SRC-1:0] onehot,
  output logic                   invalid
);

  // Compare the code against every legal position; illegal codes light nothing.
  always_comb begin
    onehot  = '0;
    invalid = ({27'd0, code} >= 32'(NUM_CODES));
    for (int i = 0; i < BUS_NUM_SRC; i++) begin
      if ((code == 5'(i)) && (i < NUM_CODES)) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_transfer_decoder.sv
// bus_transfer_decoder: sequences one register-to-register transfer over
// the shared bus (IDLE -> DRIVE -> LOAD). Enables, done and err are all
// registered; req_ready decodes the current state.
// Optional feature: define BUS_XFER_ERRCNT_EN to add a saturating
// 8-bit err_count output.
module bus_transfer_decoder
  import bus_pkg::*;
#(
  parameter int NUM_CODES = BUS_NUM_SRC
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [BUS_CODE_W-1:0]  req_src,
  input  logic [BUS_CODE_W-1:0]  req_dst,
  output logic [BUS_NUM_SRC-1:0] src_out,
  output logic [BUS_NUM_SRC-1:0] dst_in,
  output logic                   done,
  output logic                   err
`ifdef BUS_XFER_ERRCNT_EN
  ,
  output logic [7:0]             err_count
`endif
);

  bus_state_e             state_r;
  bus_state_e             state_next_s;
  logic [BUS_CODE_W-1:0]  src_q;
  logic [BUS_CODE_W-1:0]  dst_q;
  logic [BUS_CODE_W-1:0]  src_code_s;
  logic [BUS_CODE_W-1:0]  dst_code_s;
  logic [BUS_NUM_SRC-1:0] src_oh_s;
  logic [BUS_NUM_SRC-1:0] dst_oh_s;
  logic                   src_inv_s;
  logic                   dst_inv_s;
  logic                   accept_s;
  logic                   bad_req_s;
  logic [BUS_NUM_SRC-1:0] src_out_next_s;
  logic [BUS_NUM_SRC-1:0] dst_in_next_s;
  logic                   done_next_s;
  logic                   err_next_s;

  assign req_ready = (state_r != DRIVE);

  // Codes that will be held next cycle: freshly accepted ones, else the captured ones.
  always_comb begin
    accept_s = req_valid && req_ready;
    if (accept_s) begin
      src_code_s = req_src;
      dst_code_s = req_dst;
    end else begin
      src_code_s = src_q;
      dst_code_s = dst_q;
    end
    bad_req_s = src_inv_s || dst_inv_s;
  end

  bus_code_onehot #(.NUM_CODES(NUM_CODES)) u_src_dec (
    .code    (src_code_s),
    .onehot  (src_oh_s),
    .invalid (src_inv_s)
  );

  bus_code_onehot #(.NUM_CODES(NUM_CODES)) u_dst_dec (
    .code    (dst_code_s),
    .onehot  (dst_oh_s),
    .invalid (dst_inv_s)
  );

  // State register plus captured source/destination codes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= IDLE;
      src_q   <= 5'd0;
      dst_q   <= 5'd0;
    end else begin
      state_r <= state_next_s;
      src_q   <= src_code_s;
      dst_q   <= dst_code_s;
    end
  end

  // Next-state: a good accept starts DRIVE, DRIVE always moves on to LOAD.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE, LOAD: begin
        if (accept_s && !bad_req_s) begin
          state_next_s = DRIVE;
        end else begin
          state_next_s = IDLE;
        end
      end
      DRIVE:   state_next_s = LOAD;
      default: state_next_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    src_out_next_s = '0;
    dst_in_next_s  = '0;
    done_next_s    = 1'b0;
    case (state_next_s)
      DRIVE: begin
        src_out_next_s = src_oh_s;
      end
      LOAD: begin
        src_out_next_s = src_oh_s;
        dst_in_next_s  = dst_oh_s;
        done_next_s    = 1'b1;
      end
      default: begin
        src_out_next_s = '0;
      end
    endcase
    if (accept_s && bad_req_s) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = 1'b0;
    end
  end

  // Registered outputs; reset drops every enable immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      src_out <= '0;
      dst_in  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      src_out <= src_out_next_s;
      dst_in  <= dst_in_next_s;
      done    <= done_next_s;
      err     <= err_next_s;
    end
  end

`ifdef BUS_XFER_ERRCNT_EN
  // Saturating count of err pulses, cleared only by reset.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      err_count <= 8'd0;
    end else if (err_next_s && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_bus_transfer_decoder.sv
// tb_bus_transfer_decoder: directed vectors; each accepted request pushes
// its expected output cycles into a scoreboard that a negedge monitor drains.
module tb_bus_transfer_decoder;

  typedef struct {
    int          stamp;
    logic [23:0] src;
    logic [23:0] dst;
    logic        done;
    logic        err;
  } exp_t;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic [23:0] src_out;
  logic [23:0] dst_in;
  logic        done;
  logic        err;
`ifdef BUS_XFER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  bus_transfer_decoder dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .src_out   (src_out),
    .dst_in    (dst_in),
    .done      (done),
    .err       (err)
`ifdef BUS_XFER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] oh(input logic [4:0] code);
    logic [23:0] one;
    one = 24'd1;
    if (code < 5'd24) return one << code;
    else return 24'd0;
  endfunction

  // Present one request for a single edge, then record what it should produce.
  task automatic send(input logic [4:0] s, input logic [4:0] d, input bit track);
    exp_t e;
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    if (track) begin
      if (s < 5'd24 && d < 5'd24) begin
        e = '{stamp: cyc, src: oh(s), dst: 24'd0, done: 1'b0, err: 1'b0};
        sb.push_back(e);
        e = '{stamp: cyc + 1, src: oh(s), dst: oh(d), done: 1'b1, err: 1'b0};
        sb.push_back(e);
      end else begin
        e = '{stamp: cyc, src: 24'd0, dst: 24'd0, done: 1'b0, err: 1'b1};
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: every cycle with any active output must match the scoreboard head.
  always @(negedge clock) begin
    exp_t e;
    if (clear && (src_out != 24'd0 || dst_in != 24'd0 || done || err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got src=%h dst=%h done=%b err=%b expected nothing",
                 src_out, dst_in, done, err);
      end else begin
        e = sb.pop_front();
        check("out_cycle", 64'(cyc), 64'(e.stamp));
        check("out_value", {14'd0, src_out, dst_in, done, err},
              {14'd0, e.src, e.dst, e.done, e.err});
      end
    end
  end

  initial begin
    clear     = 1'b0;
    req_valid = 1'b0;
    req_src   = 5'd0;
    req_dst   = 5'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_src_out", 64'(src_out), 64'd0);
    check("rst_dst_in", 64'(dst_in), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
`ifdef BUS_XFER_ERRCNT_EN
    check("rst_err_count", 64'(err_count), 64'd0);
`endif

    // Single transfer R4 -> PC
    send(5'd4, 5'd20, 1'b1);
    check("drive_ready", 64'(req_ready), 64'd0);
    repeat (4) @(posedge clock);
    #1;

    // Back-to-back MDR -> R2 then HI -> R7 accepted in the LOAD cycle
    send(5'd21, 5'd2, 1'b1);
    @(posedge clock);
    #1;
    check("load_ready", 64'(req_ready), 64'd1);
    send(5'd16, 5'd7, 1'b1);
    repeat (4) @(posedge clock);
    #1;

    // src == dst is legal
    send(5'd9, 5'd9, 1'b1);
    repeat (3) @(posedge clock);
    #1;

    // Invalid source code
    send(5'd25, 5'd3, 1'b1);
    check("err_ready", 64'(req_ready), 64'd1);
`ifdef BUS_XFER_ERRCNT_EN
    check("err_count_first", 64'(err_count), 64'd1);
`endif
    repeat (3) @(posedge clock);
    #1;

    // Invalid destination code at the boundary of the legal range
    send(5'd23, 5'd24, 1'b1);
    repeat (2) @(posedge clock);
    #1;

    // Reset during DRIVE of C -> R5: enables drop at once, no done afterwards
    send(5'd23, 5'd5, 1'b0);
    check("mid_drive_src", 64'(src_out), 64'(oh(5'd23)));
    #2;
    clear = 1'b0;
    #1;
    check("clr_src_out", 64'(src_out), 64'd0);
    check("clr_dst_in", 64'(dst_in), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("post_clr_ready", 64'(req_ready), 64'd1);
    repeat (4) @(posedge clock);
    #1;

    // Transfer still works after reset: LO -> InPort
    send(5'd17, 5'd22, 1'b1);
    repeat (3) @(posedge clock);
    #1;

`ifdef BUS_XFER_ERRCNT_EN
    // Saturation of the error counter
    check("err_count_pre_sat", 64'(err_count), 64'd0);
    for (int i = 0; i < 260; i++) begin
      send(5'd31, 5'd0, 1'b1);
    end
    check("err_count_sat", 64'(err_count), 64'd255);
    repeat (2) @(posedge clock);
    #1;
`endif

    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
